// File: rtl/controller_pkg.sv
// Shared types and constants for the target controller TX arbitration path.
package controller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tx_arb_state_e;

  typedef enum logic {
    TX_BIT  = 1'b0,
    TX_BYTE = 1'b1
  } tx_kind_e;

  localparam int unsigned ReqTarget  = 0;
  localparam int unsigned ReqIbi     = 1;
  localparam int unsigned ReqHotJoin = 2;
  localparam int unsigned ReqCcc     = 3;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i3c_arb_picker.sv
// Combinational winner select: first requester at or after ptr, wrapping.
// With ptr tied to zero this is plain fixed priority, index 0 highest.
module i3c_arb_picker #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   grant_c,
  output logic [IdxWidth-1:0] idx_c,
  output logic                valid_c
);

  int unsigned pos;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NumReq) pos = pos - NumReq;
      if (!valid_c && req[pos]) begin
        valid_c      = 1'b1;
        idx_c        = IdxWidth'(pos);
        grant_c[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i3c_bus_tx_arbiter.sv
// Shares the bus TX engine among the target FSM family, one grant at a time.
// Define I3C_TX_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module i3c_bus_tx_arbiter
  import controller_pkg::*;
#(
  parameter int unsigned NumReq       = 4,
  parameter int unsigned TxDataWidth  = 8,
  parameter int unsigned TimeoutWidth = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_byte_i,
  input  logic [NumReq-1:0]             req_bit_i,
  input  logic [NumReq*TxDataWidth-1:0] req_value_i,
  input  logic [NumReq-1:0]             lock_i,
  output logic [NumReq-1:0]             grant_o,
  output logic [NumReq-1:0]             done_o,
  output logic [NumReq-1:0]             err_o,
  output logic                          bus_tx_req_byte_o,
  output logic                          bus_tx_req_bit_o,
  output logic [TxDataWidth-1:0]        bus_tx_req_value_o,
  input  logic                          bus_tx_done_i,
  input  logic                          bus_tx_req_err_i,
  input  logic                          bus_tx_idle_i,
  input  logic                          bus_stop_det_i,
  input  logic [TimeoutWidth-1:0]       timeout_limit_i,
  output logic                          timeout_o
);

  localparam int unsigned IdxWidth = idx_width(NumReq);

  tx_arb_state_e           state_q, state_d;
  tx_kind_e                kind;
  logic [IdxWidth-1:0]     owner_q, owner_d;
  logic                    sticky_q, sticky_d;
  logic [TimeoutWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0]     ptr_q;

  logic [NumReq-1:0]       grant_d, done_d, err_d;
  logic                    byte_d, bit_d, timeout_d;
  logic [TxDataWidth-1:0]  value_d;

  logic [NumReq-1:0]       req_any, cand;
  logic [NumReq-1:0]       pick_grant;
  logic [IdxWidth-1:0]     pick_idx;
  logic                    pick_valid;
  logic                    exit_wait;

  logic [TxDataWidth-1:0]  req_value [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_value
    assign req_value[i] = req_value_i[i*TxDataWidth +: TxDataWidth];
  end

  assign req_any = req_byte_i | req_bit_i;

  // A sticky owner is the only candidate until it releases the lock.
  always_comb begin
    cand = req_any;
    if (sticky_q) cand = req_any & (NumReq'(1) << owner_q);
  end

`ifdef I3C_TX_ARB_RR_EN
  logic [IdxWidth-1:0] ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (exit_wait) begin
      ptr_d = (owner_q == IdxWidth'(NumReq - 1)) ? '0 : owner_q + IdxWidth'(1);
    end
  end
`else
  assign ptr_q = '0;
`endif

  i3c_arb_picker #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_picker (
    .req     (cand),
    .ptr     (ptr_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= IDLE;
      owner_q            <= '0;
      sticky_q           <= 1'b0;
      cnt_q              <= '0;
      grant_o            <= '0;
      done_o             <= '0;
      err_o              <= '0;
      bus_tx_req_byte_o  <= 1'b0;
      bus_tx_req_bit_o   <= 1'b0;
      bus_tx_req_value_o <= '0;
      timeout_o          <= 1'b0;
    end else begin
      state_q            <= state_d;
      owner_q            <= owner_d;
      sticky_q           <= sticky_d;
      cnt_q              <= cnt_d;
      grant_o            <= grant_d;
      done_o             <= done_d;
      err_o              <= err_d;
      bus_tx_req_byte_o  <= byte_d;
      bus_tx_req_bit_o   <= bit_d;
      bus_tx_req_value_o <= value_d;
      timeout_o          <= timeout_d;
    end
  end

  // Next state, latched transfer and completion routing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    grant_d   = grant_o;
    byte_d    = bus_tx_req_byte_o;
    bit_d     = bus_tx_req_bit_o;
    value_d   = bus_tx_req_value_o;
    done_d    = '0;
    err_d     = '0;
    timeout_d = 1'b0;
    kind      = TX_BIT;
    exit_wait = 1'b0;

    case (state_q)
      IDLE: begin
        if (sticky_q && !req_any[owner_q] && !lock_i[owner_q]) sticky_d = 1'b0;
        if (bus_tx_idle_i && pick_valid) begin
          kind    = req_byte_i[pick_idx] ? TX_BYTE : TX_BIT;
          state_d = WAIT;
          owner_d = pick_idx;
          grant_d = pick_grant;
          byte_d  = (kind == TX_BYTE);
          bit_d   = (kind == TX_BIT);
          value_d = req_value[pick_idx];
          cnt_d   = '0;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + TimeoutWidth'(1);
        if (bus_tx_req_err_i) begin
          err_d[owner_q] = 1'b1;
          sticky_d       = lock_i[owner_q];
          exit_wait      = 1'b1;
        end else if (bus_tx_done_i) begin
          done_d[owner_q] = 1'b1;
          sticky_d        = lock_i[owner_q];
          exit_wait       = 1'b1;
        end else if (bus_stop_det_i) begin
          err_d[owner_q] = 1'b1;
          sticky_d       = 1'b0;
          exit_wait      = 1'b1;
        end else if (timeout_limit_i != '0 && cnt_q == timeout_limit_i) begin
          err_d[owner_q] = 1'b1;
          timeout_d      = 1'b1;
          sticky_d       = 1'b0;
          exit_wait      = 1'b1;
        end
        if (exit_wait) begin
          state_d = IDLE;
          grant_d = '0;
          byte_d  = 1'b0;
          bit_d   = 1'b0;
          value_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
